// File: rtl/pipeline_trace_capture_if.sv
// Read-side stream of captured trace entries: {pc, alu_result} head with valid/ready.
interface pipeline_trace_capture_if;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/pipeline_trace_capture.sv
// Trigger-armed trace recorder: captures {test_pc, test_alu_result} into a FIFO
// after a PC match and lets a host drain it over a valid/ready stream.
module pipeline_trace_capture #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            test_pc,
    input  logic [31:0]            test_alu_result,
    input  logic                   arm,
    input  logic [31:0]            trig_pc,
    input  logic [LEN_W-1:0]       capture_len,
    pipeline_trace_capture_if.master trace,
    output logic [1:0]             state,
    output logic                   overflow,
    output logic [PTR_W:0]         count
);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        DONE    = 2'b11
    } state_e;

    state_e              st_q;
    logic [31:0]         trig_pc_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    taken_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;

    logic [DATA_W-1:0]   sample;
    logic                match;
    logic                push_req;
    logic                pop;
    logic                full;
    logic                push;
    logic                drop;
    logic [LEN_W-1:0]    taken_nx;
    logic [PTR_W-1:0]    rd_nx;
    logic [CNT_W-1:0]    cnt_nx;
    logic [DATA_W-1:0]   head_d;

    assign state = st_q;

    // Push/pop decisions; a pop on an arm cycle is discarded along with the FIFO.
    always_comb begin
        sample   = {test_pc, test_alu_result};
        match    = (st_q == ARMED) && (test_pc == trig_pc_q);
        push_req = !arm && (match || (st_q == CAPTURE));
        pop      = trace.out_valid && trace.out_ready && !arm;
        full     = (count == CNT_W'(DEPTH));
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        taken_nx = taken_q + LEN_W'(1);
        rd_nx    = rd_ptr + PTR_W'(pop);
        cnt_nx   = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Next head value so out_data can be registered; a push into a drained FIFO bypasses memory.
    always_comb begin
        head_d = '0;
        if (cnt_nx != '0) begin
            if (push && (count == CNT_W'(pop))) begin
                head_d = sample;
            end else begin
                head_d = mem[rd_nx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q            <= IDLE;
            trig_pc_q       <= '0;
            len_q           <= '0;
            taken_q         <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            overflow        <= 1'b0;
            trace.out_data  <= '0;
            trace.out_valid <= 1'b0;
        end else if (arm) begin
            st_q            <= ARMED;
            trig_pc_q       <= trig_pc;
            len_q           <= (capture_len == '0) ? LEN_W'(1) : capture_len;
            taken_q         <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            overflow        <= 1'b0;
            trace.out_data  <= '0;
            trace.out_valid <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sample;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            rd_ptr          <= rd_nx;
            count           <= cnt_nx;
            trace.out_data  <= head_d;
            trace.out_valid <= (cnt_nx != '0);

            // Dropped samples still advance the taken count.
            case (st_q)
                ARMED: begin
                    if (match) begin
                        taken_q <= LEN_W'(1);
                        st_q    <= (len_q == LEN_W'(1)) ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    taken_q <= taken_nx;
                    if (taken_nx == len_q) begin
                        st_q <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_trace_capture.sv
// Self-checking bench for pipeline_trace_capture: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pipeline_trace_capture;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic [31:0] test_pc;
    logic [31:0] test_alu_result;
    logic [31:0] trig_pc;
    logic [7:0]  capture_len;
    logic [1:0]  state;
    logic        overflow;
    logic [4:0]  count;

    always #5 clk = ~clk;

    pipeline_trace_capture_if tif();

    pipeline_trace_capture #(.DEPTH(16), .PTR_W(4), .LEN_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .test_pc         (test_pc),
        .test_alu_result (test_alu_result),
        .arm             (arm),
        .trig_pc         (trig_pc),
        .capture_len     (capture_len),
        .trace           (tif.master),
        .state           (state),
        .overflow        (overflow),
        .count           (count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: spec rules over a plain queue.
    int          m_st;
    logic [31:0] m_trig;
    int          m_len;
    int          m_taken;
    bit          m_ovf;
    logic [63:0] q[$];

    typedef struct {
        logic        a;
        logic [31:0] tp;
        logic [7:0]  cl;
        logic [31:0] pc;
        logic        rdy;
        logic [1:0]  st;
        logic [4:0]  cnt;
        logic [63:0] d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic a, logic [31:0] tp, logic [7:0] cl, logic [31:0] pc,
                               logic rdy, logic [1:0] st, logic [4:0] cnt, logic [63:0] d);
        vec_t r;
        r.a = a; r.tp = tp; r.cl = cl; r.pc = pc; r.rdy = rdy;
        r.st = st; r.cnt = cnt; r.d = d;
        return r;
    endfunction

    function automatic logic [63:0] smp(logic [31:0] pc);
        return {pc, pc + 32'd1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit rec;
        bit hit;
        if (reset) begin
            m_st = 0; m_trig = '0; m_len = 0; m_taken = 0; m_ovf = 0;
            q.delete();
        end else if (arm) begin
            m_st = 1; m_trig = trig_pc;
            m_len = (capture_len == 8'd0) ? 1 : int'(capture_len);
            m_taken = 0; m_ovf = 0;
            q.delete();
        end else begin
            hit = (m_st == 1) && (test_pc == m_trig);
            rec = hit || (m_st == 2);
            if (q.size() > 0 && tif.out_ready) void'(q.pop_front());
            if (rec) begin
                if (q.size() < DEPTH) q.push_back({test_pc, test_alu_result});
                else m_ovf = 1;
            end
            if (hit) begin
                m_taken = 1;
                m_st = (m_taken >= m_len) ? 3 : 2;
            end else if (m_st == 2) begin
                m_taken++;
                if (m_taken >= m_len) m_st = 3;
            end
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".state"},    64'(state),         64'(m_st));
        chk({tag, ".count"},    64'(count),         64'(q.size()));
        chk({tag, ".valid"},    64'(tif.out_valid), 64'(q.size() != 0));
        chk({tag, ".data"},     tif.out_data,       (q.size() != 0) ? q[0] : 64'h0);
        chk({tag, ".overflow"}, 64'(overflow),      64'(m_ovf));
    endtask

    task automatic cyc(input logic r, input logic a, input logic [31:0] tp, input logic [7:0] cl,
                       input logic [31:0] pc, input logic rdy);
        reset = r; arm = a; trig_pc = tp; capture_len = cl;
        test_pc = pc; test_alu_result = pc + 32'd1; tif.out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; trig_pc = '0; capture_len = '0;
        test_pc = '0; test_alu_result = '0; tif.out_ready = 1'b0;

        // Reset held with arm asserted
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 32'h10, 8'd3, 32'h10, 1'b1);
            chk("rst.state", 64'(state), 64'd0);
            chk("rst.valid", 64'(tif.out_valid), 64'd0);
            chk("rst.count", 64'(count), 64'd0);
            chk("rst.ovf",   64'(overflow), 64'd0);
            chk("rst.data",  tif.out_data, 64'd0);
        end

        // Basic capture, len=0, arm-cycle match, re-arm mid-capture
        tbl.push_back(v(1, 32'h10, 3, 32'h00, 0, 2'd1, 5'd0, 64'h0));
        tbl.push_back(v(0, 0, 0, 32'h08, 0, 2'd1, 5'd0, 64'h0));
        tbl.push_back(v(0, 0, 0, 32'h0C, 0, 2'd1, 5'd0, 64'h0));
        tbl.push_back(v(0, 0, 0, 32'h10, 0, 2'd2, 5'd1, 64'h00000010_00000011));
        tbl.push_back(v(0, 0, 0, 32'h14, 0, 2'd2, 5'd2, 64'h00000010_00000011));
        tbl.push_back(v(0, 0, 0, 32'h18, 0, 2'd3, 5'd3, 64'h00000010_00000011));
        tbl.push_back(v(0, 0, 0, 32'h1C, 0, 2'd3, 5'd3, 64'h00000010_00000011));
        tbl.push_back(v(0, 0, 0, 32'h20, 1, 2'd3, 5'd2, 64'h00000014_00000015));
        tbl.push_back(v(0, 0, 0, 32'h24, 1, 2'd3, 5'd1, 64'h00000018_00000019));
        tbl.push_back(v(0, 0, 0, 32'h28, 1, 2'd3, 5'd0, 64'h0));
        tbl.push_back(v(0, 0, 0, 32'h2C, 1, 2'd3, 5'd0, 64'h0));
        tbl.push_back(v(1, 32'h50, 0, 32'h50, 0, 2'd1, 5'd0, 64'h0));
        tbl.push_back(v(0, 0, 0, 32'h54, 0, 2'd1, 5'd0, 64'h0));
        tbl.push_back(v(0, 0, 0, 32'h50, 0, 2'd3, 5'd1, 64'h00000050_00000051));
        tbl.push_back(v(0, 0, 0, 32'h50, 0, 2'd3, 5'd1, 64'h00000050_00000051));
        tbl.push_back(v(0, 0, 0, 32'h00, 1, 2'd3, 5'd0, 64'h0));
        tbl.push_back(v(1, 32'h30, 10, 32'h00, 0, 2'd1, 5'd0, 64'h0));
        tbl.push_back(v(0, 0, 0, 32'h30, 0, 2'd2, 5'd1, 64'h00000030_00000031));
        tbl.push_back(v(0, 0, 0, 32'h34, 0, 2'd2, 5'd2, 64'h00000030_00000031));
        tbl.push_back(v(0, 0, 0, 32'h38, 0, 2'd2, 5'd3, 64'h00000030_00000031));
        tbl.push_back(v(0, 0, 0, 32'h3C, 0, 2'd2, 5'd4, 64'h00000030_00000031));
        tbl.push_back(v(0, 0, 0, 32'h40, 0, 2'd2, 5'd5, 64'h00000030_00000031));
        tbl.push_back(v(1, 32'h40, 2, 32'h40, 1, 2'd1, 5'd0, 64'h0));
        tbl.push_back(v(0, 0, 0, 32'h40, 1, 2'd2, 5'd1, 64'h00000040_00000041));
        tbl.push_back(v(0, 0, 0, 32'h44, 0, 2'd3, 5'd2, 64'h00000040_00000041));

        foreach (tbl[i]) begin
            cyc(1'b0, tbl[i].a, tbl[i].tp, tbl[i].cl, tbl[i].pc, tbl[i].rdy);
            chk($sformatf("vec%0d.state", i), 64'(state), 64'(tbl[i].st));
            chk($sformatf("vec%0d.count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("vec%0d.valid", i), 64'(tif.out_valid), 64'(tbl[i].cnt != 0));
            chk($sformatf("vec%0d.data", i),  tif.out_data, tbl[i].d);
            chk($sformatf("vec%0d.ovf", i),   64'(overflow), 64'd0);
        end

        // Overflow: 20 samples into a 16-entry FIFO with no reader
        cyc(1'b0, 1'b1, 32'h100, 8'd20, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 8'd0, 32'h100 + 32'(4 * i), 1'b0);
            if (i == 15) begin
                chk("ovf.count15", 64'(count), 64'd16);
                chk("ovf.flag15",  64'(overflow), 64'd0);
            end
        end
        chk("ovf.count", 64'(count), 64'd16);
        chk("ovf.flag",  64'(overflow), 64'd1);
        chk("ovf.state", 64'(state), 64'd3);
        cyc(1'b0, 1'b0, 32'h0, 8'd0, 32'h150, 1'b0);
        chk("ovf.hold", 64'(count), 64'd16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("ovf.drain%0d", k), tif.out_data, smp(32'h100 + 32'(4 * k)));
            cyc(1'b0, 1'b0, 32'h0, 8'd0, 32'h0, 1'b1);
        end
        chk("ovf.empty", 64'(tif.out_valid), 64'd0);
        chk("ovf.sticky", 64'(overflow), 64'd1);

        // Full FIFO with a concurrent pop: push accepted, no overflow
        cyc(1'b0, 1'b1, 32'h200, 8'd30, 32'h0, 1'b0);
        chk("full.ovf_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 8'd0, 32'h200 + 32'(4 * i), 1'(i >= 16));
            if (i >= 16) begin
                chk($sformatf("full.count%0d", i), 64'(count), 64'd16);
                chk($sformatf("full.ovf%0d", i), 64'(overflow), 64'd0);
            end
        end
        chk("full.state", 64'(state), 64'd3);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("full.drain%0d", k), tif.out_data, smp(32'h200 + 32'(4 * (14 + k))));
            cyc(1'b0, 1'b0, 32'h0, 8'd0, 32'h0, 1'b1);
        end
        chk("full.empty", 64'(tif.out_valid), 64'd0);

        // Reset during capture leaves an empty FIFO in IDLE
        cyc(1'b0, 1'b1, 32'h300, 8'd10, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 8'd0, 32'h300, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 8'd0, 32'h304, 1'b0);
        chk("midrst.pre", 64'(count), 64'd2);
        cyc(1'b1, 1'b0, 32'h0, 8'd0, 32'h308, 1'b0);
        chk("midrst.state", 64'(state), 64'd0);
        chk("midrst.count", 64'(count), 64'd0);
        chk("midrst.valid", 64'(tif.out_valid), 64'd0);
        chk("midrst.data",  tif.out_data, 64'd0);
        cyc(1'b0, 1'b0, 32'h0, 8'd0, 32'h0, 1'b0);
        chk("midrst.idle", 64'(state), 64'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic       r;
            logic       a;
            logic       rdy;
            r   = ($urandom_range(0, 199) == 0);
            a   = ($urandom_range(0, 29) == 0);
            rdy = (n < 1500) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            cyc(r, a, 32'(4 * $urandom_range(0, 7)), 8'($urandom_range(0, 20)),
                32'(4 * $urandom_range(0, 7)), rdy);
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
